sram_1r1w_req_adapter: RTL

- Valid/ready front end that drives one simple-dual-port (1R1W) behavioural SRAM macro with 1-cycle registered-address read latency.
- Sits directly upstream of the macro, between cache/scratchpad control logic and the SRAM.
- After reset, zero-fills the array, then gives in-order read responses with a 2-entry response buffer.
- Guarantees write-first semantics for a same-cycle read and write to the same address by byte-merging the write into the read data, independent of what the macro itself does.

---
 rtl/sram_1r1w_req_adapter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sram_1r1w_req_adapter.sv
// Valid/ready front end for a 1R1W SRAM macro with 1-cycle read latency.
// Zero-fills the array after reset, forwards same-cycle writes into reads, buffers two responses.
module sram_1r1w_req_adapter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 64,
  parameter int MASK_W    = DATA_W / 8,
  parameter int INIT_ZERO = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  // Handshakes: a transfer happens in every cycle where valid && ready are both
  // high at the rising edge; valid never waits on ready, and ready never
  // depends combinationally on r_resp_ready.
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [MASK_W-1:0] w_mask,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data,
  output logic [MASK_W-1:0] sram_w_mask,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              dbg_state
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_init_done;

  logic                r_inflight;
  logic                r_fwd_hit;
  logic [DATA_W-1:0]   r_fwd_data;
  logic [MASK_W-1:0]   r_fwd_mask;

  logic [DATA_W-1:0]   r_fifo [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_occ;

  logic                w_wr_fire;
  logic                w_rd_fire;
  logic                w_enq;
  logic                w_deq;
  logic                w_fifo_nonempty;
  logic [DATA_W-1:0]   w_merged;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt <= r_cnt + ADDR_W'(1);
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_cnt == '1) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = r_state;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Everything is gated by reset so no macro enable fires in the cycle reset is sampled.
  always_comb begin
    sram_w_en   = 1'b0;
    sram_w_addr = w_addr;
    sram_w_data = w_data;
    sram_w_mask = w_mask;
    w_ready     = 1'b0;
    r_req_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_INIT: begin
          sram_w_en   = 1'b1;
          sram_w_addr = r_cnt;
          sram_w_data = '0;
          sram_w_mask = '1;
        end
        ST_RUN: begin
          w_ready     = 1'b1;
          r_req_ready = ((2'(r_inflight) + r_occ) < 2'd2);
          sram_w_en   = w_valid;
        end
        default: ;
      endcase
    end
  end

  assign init_done = r_init_done;
  assign dbg_state = r_state;

  assign w_wr_fire   = w_valid && w_ready;
  assign w_rd_fire   = r_req_valid && r_req_ready;
  assign sram_r_en   = w_rd_fire;
  assign sram_r_addr = r_req_addr;

  // Capture the write that collides with a read so its bytes override the macro output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_mask <= '0;
    end else begin
      r_inflight <= w_rd_fire;
      r_fwd_hit  <= w_rd_fire && w_wr_fire && (r_req_addr == w_addr);
      r_fwd_data <= w_data;
      r_fwd_mask <= w_mask;
    end
  end

  always_comb begin
    w_merged = sram_r_data;
    for (int i = 0; i < MASK_W; i++) begin
      if (r_fwd_hit && r_fwd_mask[i]) w_merged[8*i +: 8] = r_fwd_data[8*i +: 8];
    end
  end

  // ---------------- response path ----------------
  // An empty buffer lets the fresh word bypass straight to the consumer.
  assign w_fifo_nonempty = (r_occ != 2'd0);
  assign r_resp_valid    = !reset && (w_fifo_nonempty || r_inflight);
  assign r_resp_data     = w_fifo_nonempty ? r_fifo[r_rptr] : w_merged;
  assign w_deq           = w_fifo_nonempty && r_resp_ready;
  assign w_enq           = r_inflight && (w_fifo_nonempty || !r_resp_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_occ <= r_occ + 2'(w_enq) - 2'(w_deq);
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq) r_fifo[r_wptr] <= w_merged;
  end

endmodule
